// File: rtl/cpu_timing_pkg.sv
// Shared timing constants for the hardwired controller: one-hot beat codes,
// phase ring encodings and the beat sequencing rule.
package cpu_timing_pkg;

  localparam logic [2:0] BEAT_W1 = 3'b001;
  localparam logic [2:0] BEAT_W2 = 3'b010;
  localparam logic [2:0] BEAT_W3 = 3'b100;

  localparam int PH_T1 = 0;
  localparam int PH_T2 = 1;
  localparam int PH_T3 = 2;
  localparam int PH_T4 = 3;

  localparam logic [3:0] PHASE_T1 = 4'(1 << PH_T1);
  localparam logic [3:0] PHASE_T2 = 4'(1 << PH_T2);
  localparam logic [3:0] PHASE_T3 = 4'(1 << PH_T3);
  localparam logic [3:0] PHASE_T4 = 4'(1 << PH_T4);

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Any non-one-hot beat (upset) recovers to W1 on the next advance.
  function automatic logic [2:0] next_beat(input logic [2:0] w,
                                           input logic       short_req,
                                           input logic       long_req);
    logic [2:0] nb;
    nb = BEAT_W1;
    case (w)
      BEAT_W1: nb = short_req ? BEAT_W1 : BEAT_W2;
      BEAT_W2: nb = long_req  ? BEAT_W3 : BEAT_W1;
      default: nb = BEAT_W1;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/beat_timing_gen_if.sv
// Controller-facing bundle: cycle-length/stop requests in, beat and phase ring out.
interface beat_timing_gen_if;
  logic       SHORT;
  logic       LONG;
  logic       STOP;
  logic       T1;
  logic       T2;
  logic       T3;
  logic       T4;
  logic [2:0] W;
  logic       RUN;

  modport master (
    input  SHORT, LONG, STOP,
    output T1, T2, T3, T4, W, RUN
  );

  modport slave (
    output SHORT, LONG, STOP,
    input  T1, T2, T3, T4, W, RUN
  );
endinterface

// File: rtl/qd_debounce.sv
// Start-button conditioning: synchroniser, saturating debounce counter and a
// single-cycle press pulse that re-arms only after the button is released.
module qd_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic CLK,
  input  logic CLR,
  input  logic QD,
  output logic PRESS
);
  localparam int             CNT_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   fired;
  logic                   qd_s;

  assign qd_s  = sync[SYNC_STAGES-1];
  assign PRESS = qd_s && (cnt == CNT_MAX) && !fired;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync  <= '0;
      cnt   <= '0;
      fired <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], QD};
      if (!qd_s) begin
        cnt   <= '0;
        fired <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        // Latch the pulse so a held button yields exactly one press.
        if (PRESS) fired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/beat_timing_gen.sv
// Beat (W1..W3) and four-phase ring (T1..T4) generator for the hardwired
// controller; started by a debounced QD press, shaped by SHORT/LONG/STOP.
module beat_timing_gen
  import cpu_timing_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              QD,
  beat_timing_gen_if.master bus
);
  run_state_e state;
  logic [3:0] t;
  logic [2:0] w;
  logic       press;

  qd_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE)
  ) u_deb (
    .CLK  (CLK),
    .CLR  (CLR),
    .QD   (QD),
    .PRESS(press)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= ST_HALT;
      t     <= '0;
      w     <= BEAT_W1;
    end else begin
      case (state)
        ST_HALT: begin
          if (press) begin
            state <= ST_RUN;
            t     <= PHASE_T1;
          end
        end
        ST_RUN: begin
          // Requests matter only on the edge that closes T4; a press is ignored.
          case (t)
            PHASE_T1: t <= PHASE_T2;
            PHASE_T2: t <= PHASE_T3;
            PHASE_T3: t <= PHASE_T4;
            PHASE_T4: begin
              w <= next_beat(w, bus.SHORT, bus.LONG);
              if (bus.STOP) begin
                state <= ST_HALT;
                t     <= '0;
              end else begin
                t <= PHASE_T1;
              end
            end
            default: t <= PHASE_T1;
          endcase
        end
      endcase
    end
  end

  assign bus.T1  = t[PH_T1];
  assign bus.T2  = t[PH_T2];
  assign bus.T3  = t[PH_T3];
  assign bus.T4  = t[PH_T4];
  assign bus.W   = w;
  assign bus.RUN = (state == ST_RUN);

endmodule

// File: tb/tb_beat_timing_gen.sv
// Directed bench for beat_timing_gen: start latency, short/normal/long cycles,
// stop/resume, coincident press, bounce rejection and async clear.
module tb_beat_timing_gen;
  import cpu_timing_pkg::*;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  logic QD  = 1'b0;
  int   nvec   = 0;
  int   nerr   = 0;
  int   npress = 0;
  int   p0;
  int   n;

  beat_timing_gen_if bus ();

  beat_timing_gen #(
    .SYNC_STAGES(2),
    .DEBOUNCE   (4)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .QD (QD),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (dut.press) npress++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] obs();
    return 32'({bus.RUN, bus.W, bus.T4, bus.T3, bus.T2, bus.T1});
  endfunction

  // Expected {RUN, W, T4..T1}; ph < 0 means no phase active.
  function automatic logic [31:0] st(input logic run, input logic [2:0] w, input int ph);
    logic [3:0] tt;
    tt = (ph < 0) ? 4'b0000 : 4'(1 << ph);
    return 32'({run, w, tt});
  endfunction

  initial begin
    logic [2:0] ew;
    bus.SHORT = 1'b0;
    bus.LONG  = 1'b0;
    bus.STOP  = 1'b0;

    // Reset, with QD asserted to show CLR dominates
    repeat (3) tick();
    chk("reset", obs(), st(1'b0, BEAT_W1, -1));
    QD = 1'b1;
    tick(); tick();
    chk("reset_dom", obs(), st(1'b0, BEAT_W1, -1));
    QD  = 1'b0;
    CLR = 1'b1;
    repeat (3) tick();
    chk("idle", obs(), st(1'b0, BEAT_W1, -1));

    // Start: raw QD to T1 takes 2 + 4 + 1 clocks
    bus.SHORT = 1'b1;
    p0 = npress;
    QD = 1'b1;
    n  = 0;
    while (n < 20 && !bus.T1) begin
      tick();
      n++;
      if (n == 6) chk("pre_start", obs(), st(1'b0, BEAT_W1, -1));
    end
    chk("start_latency", 32'(n), 32'd7);

    // Short cycles: W stays W1
    for (int i = 0; i < 12; i++) begin
      chk("short_ring", obs(), st(1'b1, BEAT_W1, i % 4));
      if (i == 2) QD = 1'b0;
      tick();
    end
    chk("short_wrap", obs(), st(1'b1, BEAT_W1, 0));
    chk("one_press", 32'(npress - p0), 32'd1);

    // Normal cycles W1,W2,W1,W2 with a press arriving mid-run
    bus.SHORT = 1'b0;
    QD = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ew = ((i / 4) % 2 == 1) ? BEAT_W2 : BEAT_W1;
      chk("normal", obs(), st(1'b1, ew, i % 4));
      if (i == 10) QD = 1'b0;
      tick();
    end
    chk("run_press_seen", 32'(npress - p0), 32'd2);

    // Long cycle; LONG in W1 and SHORT in W3 ignored; SHORT beats LONG in W1
    for (int i = 0; i < 16; i++) begin
      ew = (i < 4) ? BEAT_W1 : (i < 8) ? BEAT_W2 : (i < 12) ? BEAT_W3 : BEAT_W1;
      chk("long", obs(), st(1'b1, ew, i % 4));
      bus.LONG  = (i == 3 || i == 7 || i == 15);
      bus.SHORT = (i == 11 || i == 15);
      tick();
    end
    chk("short_wins", obs(), st(1'b1, BEAT_W1, 0));
    bus.LONG  = 1'b0;
    bus.SHORT = 1'b0;

    // Stop at W1 T4: beat advances to W2, then holds halted
    for (int i = 0; i < 4; i++) begin
      chk("pre_stop", obs(), st(1'b1, BEAT_W1, i));
      bus.STOP = (i == 3);
      tick();
    end
    bus.STOP = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("halt", obs(), st(1'b0, BEAT_W2, -1));
      tick();
    end

    // Resume at T1 of the held beat, one clock after the press pulse
    QD = 1'b1;
    n  = 0;
    while (n < 20 && !dut.press) begin
      tick();
      n++;
    end
    chk("resume_press_found", 32'(n < 20), 32'd1);
    chk("pre_resume", obs(), st(1'b0, BEAT_W2, -1));
    QD = 1'b0;
    tick();
    chk("resume", obs(), st(1'b1, BEAT_W2, 0));

    // Press lands on the same edge STOP is sampled: stays halted
    tick();
    chk("w2t2", obs(), st(1'b1, BEAT_W2, 1));
    QD = 1'b1;
    repeat (6) tick();
    chk("coinc_t4", obs(), st(1'b1, BEAT_W1, 3));
    chk("coinc_press", 32'(dut.press), 32'd1);
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;
    chk("coinc_halt", obs(), st(1'b0, BEAT_W2, -1));
    repeat (5) tick();
    chk("coinc_stay", obs(), st(1'b0, BEAT_W2, -1));
    QD = 1'b0;

    // Bounce shorter than the debounce window: no start
    repeat (4) tick();
    QD = 1'b1; tick(); tick();
    QD = 1'b0; tick();
    QD = 1'b1; tick(); tick();
    QD = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bounce", obs(), st(1'b0, BEAT_W2, -1));
      tick();
    end

    // Restart, run to W2 T3, then clear asynchronously between edges
    QD = 1'b1;
    n  = 0;
    while (n < 20 && !bus.T1) begin
      tick();
      n++;
    end
    chk("restart_latency", 32'(n), 32'd7);
    QD = 1'b0;
    chk("restart", obs(), st(1'b1, BEAT_W2, 0));
    tick(); tick();
    chk("w2t3", obs(), st(1'b1, BEAT_W2, 2));
    #2 CLR = 1'b0;
    #1 chk("async_clr", obs(), st(1'b0, BEAT_W1, -1));
    tick();
    chk("clr_hold", obs(), st(1'b0, BEAT_W1, -1));
    CLR = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/beat_timing_gen.md
Name: beat_timing_gen

Overview:
- Upstream timing stage for the hardwired controller. It generates the one-hot beat vector W[3:1] and the four-phase clock ring T1..T4 that the controller consumes.
- It consumes the controller's SHORT, LONG and STOP requests to shorten, lengthen or halt the machine cycle.
- It restarts on a debounced QD (start) button press.
- It runs from the fast board clock CLK; the controller's T3 is taken from this block's T3 output.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising raw QD into the CLK domain (minimum 2).
- DEBOUNCE, 4: number of consecutive CLK cycles synchronised QD must be high before a press is recognised (minimum 1).

Ports:
- CLK  in  1  board clock; all state updates on its rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- QD  in  1  raw start button, asynchronous, active-high.
- SHORT  in  1  from controller: the machine cycle ends after W1.
- LONG  in  1  from controller: the machine cycle continues to W3 after W2.
- STOP  in  1  from controller: halt after the current beat.
- T1, T2, T3, T4  out  1 each  one-hot phase ring; all low while halted.
- W  out  3  one-hot beat W[3:1].
- RUN  out  1  high while phases are cycling.

Behaviour:
- Reset (CLR low, async): W=3'b001, T1..T4=0, RUN=0, debounce counter=0, press latch=0, sync chain=0. CLR low dominates every other input.
- QD path:
  - SYNC_STAGES-flop synchroniser, then a saturating counter.
  - The counter increments while synced QD=1 and clears to 0 when synced QD=0.
  - A press pulse lasts exactly one CLK, on the cycle the counter reaches DEBOUNCE.
  - No further pulse is generated until synced QD returns to 0.
- Press pulse while RUN=0: RUN=1 next cycle and T1=1 on that same cycle. Press pulse while RUN=1: ignored.
- Phase ring while RUN=1: T1 -> T2 -> T3 -> T4 -> T1, one CLK each, exactly one T high.
- Beat advance happens on the CLK edge that ends T4. SHORT, LONG and STOP are sampled on that edge only; they are ignored in T1-T3.
  - From W1: SHORT=1 -> W1, otherwise W2.
  - From W2: LONG=1 -> W3, otherwise W1.
  - From W3: always W1.
  - SHORT and LONG both high in W1: SHORT wins. LONG in W1 and SHORT in W2/W3 have no effect.
- STOP=1 at the end of T4:
  - W still advances per the rules above.
  - RUN=0 and all T go 0 next cycle.
  - W then holds until the next press.
  - Resume starts at T1 of the held beat.
- Press pulse in the same cycle STOP is sampled: STOP wins. The press is discarded and a new press is required.
- Latency: press pulse to T1 high = 1 CLK. Raw QD edge to T1 = SYNC_STAGES + DEBOUNCE + 1 CLK.
- W never takes a non-one-hot value. An illegal W from an upset decodes to next beat W1.
- CLR asserted mid-beat: immediate return to reset values. No partial beat completes.

Decomposition:
- Shared package cpu_timing_pkg:
  - beat constants BEAT_W1=3'b001, BEAT_W2=3'b010, BEAT_W3=3'b100.
  - phase index constants.
  - The controller reuses the beat constants.
- One sub-module: qd_debounce, containing the synchroniser, counter and single-cycle press pulse. Parameters SYNC_STAGES and DEBOUNCE; ports CLK, CLR, QD, PRESS.

Test Plan:
- Reset and start:
  - Stimulus: CLR low, then high; QD held high 10 cycles.
  - Required: RUN=0, W=001 before the press; T1 rises exactly 2+4+1=7 CLK after the first high QD sample; exactly one press.
- Short cycle:
  - Stimulus: SHORT=1 constant, run 3 machine cycles.
  - Required: W stays 001; T ring repeats T1..T4 with period 4; no W2 ever.
- Normal and long cycles:
  - Stimulus: SHORT=0, LONG=0.
  - Required: W sequence 001,010,001 every 8 CLK.
  - Stimulus: LONG=1 during W2 T4.
  - Required: W sequence 001,010,100,001 over 12 CLK.
- Stop and resume:
  - Stimulus: STOP=1 during W1 T4.
  - Required: W=010, RUN=0, T all 0 hold for 20 cycles.
  - Stimulus: then a QD press.
  - Required: T1 with W=010 one CLK after the press pulse.
- Simultaneous and ignored events:
  - Stimulus: press pulse coincident with STOP sampling.
  - Required: stays halted.
  - Stimulus: QD bounce 1-0-1 shorter than DEBOUNCE.
  - Required: no start.
  - Stimulus: press while running.
  - Required: no change to the T/W sequence.
- Async reset mid-beat:
  - Stimulus: CLR low during W2 T3, between clock edges.
  - Required: W=001, T all 0, RUN=0 immediately, without waiting for a CLK edge.
